// File: rtl/apb_cmd_master.sv
// APB3 initiator: turns a valid/ready command stream into single APB transfers, one at a time.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS phases that wait longer than TIMEOUT_CYCLES.
module apb_cmd_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e state;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] tmo_cnt;
`endif

  // Only unregistered output: new commands are taken only in IDLE and never during reset.
  assign cmd_ready = (state == StIdle) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (cmd_valid) begin
            paddr  <= cmd_addr;
            pwrite <= cmd_write;
            pwdata <= cmd_wdata;
            psel   <= 1'b1;
            state  <= StSetup;
          end
        end
        StSetup: begin
          penable <= 1'b1;
          state   <= StAccess;
`ifdef APB_MASTER_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        StAccess: begin
          // pready wins over a timeout that would expire in the same cycle.
          if (pready) begin
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= StResp;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (tmo_cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= StResp;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed self-checking bench for apb_cmd_master (timeout case runs when
// APB_MASTER_TIMEOUT_EN is defined, TIMEOUT_CYCLES=4).
module tb_apb_cmd_master;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int n_vec = 0;
  int n_err = 0;

  apb_cmd_master #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .paddr      (paddr),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are then driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a command while cmd_ready is expected high, let it be accepted, then withdraw it.
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    chk("cmd_ready_before_accept", {31'b0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    prdata    = '0;
    pready    = 1'b1;
    pslverr   = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_psel",      {31'b0, psel},      32'd0);
    chk("rst_penable",   {31'b0, penable},   32'd0);
    chk("rst_paddr",     paddr,              32'h0);
    chk("rst_rsp_rdata", rsp_rdata,          32'h0);
    reset = 1'b0;
    #1;
    chk("cmd_ready_after_release", {31'b0, cmd_ready}, 32'd1);

    // Write, no wait states: SETUP N+1, ACCESS N+2, response N+3, ready N+4
    send(1'b1, 32'h28, 32'h2);
    chk("wr_setup_psel",    {31'b0, psel},      32'd1);
    chk("wr_setup_penable", {31'b0, penable},   32'd0);
    chk("wr_setup_paddr",   paddr,              32'h28);
    chk("wr_setup_pwdata",  pwdata,             32'h2);
    chk("wr_setup_pwrite",  {31'b0, pwrite},    32'd1);
    chk("wr_setup_cmdrdy",  {31'b0, cmd_ready}, 32'd0);
    tick();
    chk("wr_acc_psel",      {31'b0, psel},      32'd1);
    chk("wr_acc_penable",   {31'b0, penable},   32'd1);
    chk("wr_acc_paddr",     paddr,              32'h28);
    chk("wr_acc_pwdata",    pwdata,             32'h2);
    chk("wr_acc_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    tick();
    chk("wr_rsp_valid",     {31'b0, rsp_valid}, 32'd1);
    chk("wr_rsp_err",       {31'b0, rsp_err},   32'd0);
    chk("wr_rsp_rdata",     rsp_rdata,          32'h0);
    chk("wr_rsp_psel",      {31'b0, psel},      32'd0);
    chk("wr_rsp_penable",   {31'b0, penable},   32'd0);
    tick();
    chk("wr_done_valid",    {31'b0, rsp_valid}, 32'd0);
    chk("wr_done_cmdrdy",   {31'b0, cmd_ready}, 32'd1);

    // Read with three wait states
    pready = 1'b0;
    send(1'b0, 32'h24, 32'hDEAD_BEEF);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rdw_psel",      {31'b0, psel},      32'd1);
      chk("rdw_penable",   {31'b0, penable},   32'd1);
      chk("rdw_paddr",     paddr,              32'h24);
      chk("rdw_pwrite",    {31'b0, pwrite},    32'd0);
      chk("rdw_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      tick();
    end
    pready = 1'b1;
    prdata = 32'h1234_5678;
    chk("rdw_last_paddr", paddr, 32'h24);
    tick();
    prdata = 32'h0;
    chk("rdw_rsp_valid_set", {31'b0, rsp_valid},   32'd1);
    chk("rdw_rsp_rdata",     rsp_rdata,            32'h1234_5678);
    chk("rdw_rsp_err",       {31'b0, rsp_err},     32'd0);
    chk("rdw_rsp_timeout",   {31'b0, rsp_timeout}, 32'd0);
    tick();

    // Back-pressure with a second command queued behind it
    rsp_ready = 1'b0;
    send(1'b1, 32'h30, 32'hAB);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h34;
    cmd_wdata = 32'h0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", rsp_rdata,          32'h0);
      chk("bp_rsp_err",   {31'b0, rsp_err},   32'd0);
      chk("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      chk("bp_psel",      {31'b0, psel},      32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    chk("bp_hs_valid", {31'b0, rsp_valid}, 32'd1);
    tick();
    chk("bp_idle_valid",  {31'b0, rsp_valid}, 32'd0);
    chk("bp_idle_cmdrdy", {31'b0, cmd_ready}, 32'd1);
    chk("bp_idle_psel",   {31'b0, psel},      32'd0);
    prdata = 32'hCAFE_F00D;
    tick();
    cmd_valid = 1'b0;
    chk("q2_setup_psel",   {31'b0, psel},   32'd1);
    chk("q2_setup_paddr",  paddr,           32'h34);
    chk("q2_setup_pwrite", {31'b0, pwrite}, 32'd0);
    tick();
    tick();
    chk("q2_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("q2_rsp_rdata", rsp_rdata,          32'hCAFE_F00D);
    prdata = 32'h0;
    tick();

    // Slave error on a read
    pslverr = 1'b1;
    send(1'b0, 32'h18, 32'h0);
    tick();
    tick();
    pslverr = 1'b0;
    chk("err_rsp_valid",   {31'b0, rsp_valid},   32'd1);
    chk("err_rsp_err",     {31'b0, rsp_err},     32'd1);
    chk("err_rsp_timeout", {31'b0, rsp_timeout}, 32'd0);
    tick();

`ifdef APB_MASTER_TIMEOUT_EN
    // Timeout after four stalled ACCESS cycles
    pready = 1'b0;
    prdata = 32'h5A5A_5A5A;
    send(1'b0, 32'h40, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_acc_psel",    {31'b0, psel},      32'd1);
      chk("to_acc_penable", {31'b0, penable},   32'd1);
      chk("to_acc_valid",   {31'b0, rsp_valid}, 32'd0);
      tick();
    end
    chk("to_psel",        {31'b0, psel},        32'd0);
    chk("to_rsp_valid",   {31'b0, rsp_valid},   32'd1);
    chk("to_rsp_err",     {31'b0, rsp_err},     32'd1);
    chk("to_rsp_timeout", {31'b0, rsp_timeout}, 32'd1);
    chk("to_rsp_rdata",   rsp_rdata,            32'h0);
    prdata = 32'h0;
    tick();
`endif

    // Reset during ACCESS drops the transfer without a response
    pready = 1'b0;
    send(1'b0, 32'h44, 32'h0);
    tick();
`ifndef APB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 100; i++) begin
      chk("hang_psel",  {31'b0, psel},      32'd1);
      chk("hang_valid", {31'b0, rsp_valid}, 32'd0);
      tick();
    end
`endif
    chk("pre_rst_penable", {31'b0, penable}, 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_psel",    {31'b0, psel},      32'd0);
    chk("mid_rst_penable", {31'b0, penable},   32'd0);
    chk("mid_rst_valid",   {31'b0, rsp_valid}, 32'd0);
    chk("mid_rst_cmdrdy",  {31'b0, cmd_ready}, 32'd0);
    chk("mid_rst_paddr",   paddr,              32'h0);
    reset  = 1'b0;
    pready = 1'b1;
    #1;
    chk("post_rst_cmdrdy", {31'b0, cmd_ready}, 32'd1);
    tick();
    chk("post_rst_valid",  {31'b0, rsp_valid}, 32'd0);

    // Recovery: a normal write completes with the usual latency
    send(1'b1, 32'h50, 32'h77);
    chk("rec_psel",  {31'b0, psel}, 32'd1);
    chk("rec_paddr", paddr,         32'h50);
    tick();
    tick();
    chk("rec_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    tick();
    chk("rec_cmdrdy", {31'b0, cmd_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
